// File: rtl/mux_serializer.sv
// Lane serializer: takes one N-lane bundle and emits its lanes (lane 0 first) one word
// per cycle on a valid/ready stream, reloading the next bundle with no bubble.
module mux_serializer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int N          = 4,
  localparam int SEL_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [SEL_WIDTH-1:0]    out_sel,
  output logic                    out_last
);

  localparam logic [0:0]           IDLE     = 1'b0;
  localparam logic [0:0]           SEND     = 1'b1;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(N - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

  logic [0:0]              r_state;
  logic [N*DATA_WIDTH-1:0] r_bundle;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;

  logic                    w_xfer;
  logic                    w_at_last;
  logic [SEL_WIDTH-1:0]    w_sel_inc;

  // Lane 0 sits in the MSBs of the bundle.
  function automatic logic [DATA_WIDTH-1:0] lane_of(
    input logic [N*DATA_WIDTH-1:0] bundle,
    input logic [SEL_WIDTH-1:0]    idx
  );
    lane_of = bundle[N*DATA_WIDTH-1 - int'(idx)*DATA_WIDTH -: DATA_WIDTH];
  endfunction

  assign w_at_last = (r_sel == LAST_SEL);
  assign w_xfer    = r_valid & out_ready;
  assign w_sel_inc = r_sel + SEL_ONE;

  // Ready is combinational from out_ready so the last lane and the next accept share an edge.
  assign in_ready  = ~rst & ((r_state == IDLE) | (w_at_last & out_ready));

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_last  = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bundle <= '0;
      r_sel    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bundle <= in_data;
            r_sel    <= '0;
            r_data   <= lane_of(in_data, '0);
            r_valid  <= 1'b1;
            r_last   <= (N == 1);
            r_state  <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (!w_at_last) begin
              r_sel  <= w_sel_inc;
              r_data <= lane_of(r_bundle, w_sel_inc);
              r_last <= (w_sel_inc == LAST_SEL);
            end else if (in_valid) begin
              // Zero-bubble reload: the last lane leaves as lane 0 of the next bundle arrives.
              r_bundle <= in_data;
              r_sel    <= '0;
              r_data   <= lane_of(in_data, '0);
              r_last   <= (N == 1);
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
